// File: rtl/reglk_ctrl.sv
// Register-lock controller: a bank of lock words that can be frozen, with a
// key-protected debug unlock window and a permanent hard lock after repeated bad keys.
module reglk_ctrl #(
    parameter int          NUM_REGS   = 6,
    parameter logic [31:0] UNLOCK_KEY = 32'hA5C3_5A3C,
    parameter int          WIN_CYCLES = 16,
    parameter int          MAX_FAIL   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_low,
    input  logic                      wr_req_i,
    input  logic [2:0]                wr_addr_i,
    input  logic [31:0]               wr_data_i,
    output logic                      wr_ack_o,
    output logic                      wr_err_o,
    input  logic                      lock_commit_i,
    input  logic                      jtag_unlock_i,
    input  logic [31:0]               jtag_key_i,
    output logic                      jtag_ack_o,
    output logic                      jtag_nack_o,
    output logic [NUM_REGS-1:0][31:0] reglk_mem_o,
    output logic                      locked_o
);

    typedef enum logic [2:0] {
        OPEN,
        LOCKED,
        CHECK,
        WINDOW,
        HARD_LOCK
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  win_cnt, win_cnt_nxt;
    logic [2:0]  fail_cnt, fail_cnt_nxt;
    logic [31:0] key_q;
    logic        writable, addr_ok, wr_take, wr_ok;
    logic        wr_ack_nxt, wr_err_nxt, jtag_ack_nxt, jtag_nack_nxt;

    assign locked_o = (state == LOCKED) || (state == CHECK) || (state == HARD_LOCK);

    always_comb begin
        writable      = (state == OPEN) || (state == WINDOW);
        // The cycle after a sampled request is its response cycle, so the held request is not re-sampled.
        wr_take       = wr_req_i && !wr_ack_o && !wr_err_o;
        addr_ok       = int'({29'd0, wr_addr_i}) < NUM_REGS;
        wr_ok         = wr_take && writable && addr_ok;
        wr_ack_nxt    = wr_ok;
        wr_err_nxt    = wr_take && !wr_ok;
        state_nxt     = state;
        win_cnt_nxt   = win_cnt;
        fail_cnt_nxt  = fail_cnt;
        jtag_ack_nxt  = 1'b0;
        jtag_nack_nxt = 1'b0;
        case (state)
            OPEN: begin
                jtag_nack_nxt = jtag_unlock_i;
                if (lock_commit_i) state_nxt = LOCKED;
            end
            LOCKED: begin
                if (jtag_unlock_i) state_nxt = CHECK;
            end
            CHECK: begin
                if (key_q == UNLOCK_KEY) begin
                    state_nxt    = WINDOW;
                    jtag_ack_nxt = 1'b1;
                    win_cnt_nxt  = 8'(WIN_CYCLES);
                    fail_cnt_nxt = 3'd0;
                end else begin
                    jtag_nack_nxt = 1'b1;
                    fail_cnt_nxt  = fail_cnt + 3'd1;
                    state_nxt     = (fail_cnt_nxt == 3'(MAX_FAIL)) ? HARD_LOCK : LOCKED;
                end
            end
            WINDOW: begin
                jtag_nack_nxt = jtag_unlock_i;
                if (lock_commit_i || win_cnt == 8'd0) begin
                    state_nxt   = LOCKED;
                    win_cnt_nxt = 8'd0;
                end else begin
                    win_cnt_nxt = win_cnt - 8'd1;
                end
            end
            HARD_LOCK: begin
                jtag_nack_nxt = jtag_unlock_i;
            end
            default: begin
                state_nxt = HARD_LOCK;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_low) begin
        if (!rst_low) begin
            state       <= OPEN;
            win_cnt     <= 8'd0;
            fail_cnt    <= 3'd0;
            key_q       <= 32'd0;
            wr_ack_o    <= 1'b0;
            wr_err_o    <= 1'b0;
            jtag_ack_o  <= 1'b0;
            jtag_nack_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            win_cnt     <= win_cnt_nxt;
            fail_cnt    <= fail_cnt_nxt;
            wr_ack_o    <= wr_ack_nxt;
            wr_err_o    <= wr_err_nxt;
            jtag_ack_o  <= jtag_ack_nxt;
            jtag_nack_o <= jtag_nack_nxt;
            if (state == LOCKED && jtag_unlock_i) key_q <= jtag_key_i;
        end
    end

    // Words only change through an accepted write, so they stay frozen outside OPEN and WINDOW.
    always_ff @(posedge clk_i or negedge rst_low) begin
        if (!rst_low) begin
            reglk_mem_o <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && wr_addr_i == 3'(i)) reglk_mem_o[i] <= wr_data_i;
            end
        end
    end

endmodule

// File: tb/tb_reglk_ctrl.sv
// Scoreboard bench for reglk_ctrl: a cycle-deadline reference model predicts responses,
// and an independent monitor pops and compares them as the DUT produces them.
module tb_reglk_ctrl;

    localparam int          NUM_REGS = 6;
    localparam logic [31:0] KEY      = 32'hA5C3_5A3C;
    localparam int          WIN      = 16;
    localparam int          MAXF     = 3;

    logic                      clk_i = 1'b0;
    logic                      rst_low = 1'b1;
    logic                      wr_req_i = 1'b0;
    logic [2:0]                wr_addr_i = 3'd0;
    logic [31:0]               wr_data_i = 32'd0;
    logic                      wr_ack_o, wr_err_o;
    logic                      lock_commit_i = 1'b0;
    logic                      jtag_unlock_i = 1'b0;
    logic [31:0]               jtag_key_i = 32'd0;
    logic                      jtag_ack_o, jtag_nack_o;
    logic [NUM_REGS-1:0][31:0] reglk_mem_o;
    logic                      locked_o;

    reglk_ctrl #(
        .NUM_REGS(NUM_REGS), .UNLOCK_KEY(KEY), .WIN_CYCLES(WIN), .MAX_FAIL(MAXF)
    ) dut (
        .clk_i(clk_i), .rst_low(rst_low),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .wr_ack_o(wr_ack_o), .wr_err_o(wr_err_o),
        .lock_commit_i(lock_commit_i),
        .jtag_unlock_i(jtag_unlock_i), .jtag_key_i(jtag_key_i),
        .jtag_ack_o(jtag_ack_o), .jtag_nack_o(jtag_nack_o),
        .reglk_mem_o(reglk_mem_o), .locked_o(locked_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int cyc; bit ok; } resp_t;
    typedef struct { int cyc; bit locked; logic [NUM_REGS-1:0][31:0] mem; } snap_t;

    resp_t wr_q[$];
    resp_t jt_q[$];
    snap_t st_q[$];
    resp_t mon_r;
    snap_t mon_s;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference model: window tracked as an absolute start edge rather than a counter.
    bit                        open_m, hard_m, win_valid, check_pending;
    int                        win_start, fails_m;
    logic [31:0]               ckey;
    logic [NUM_REGS-1:0][31:0] mem_m;

    bit          wr_hold;
    logic [2:0]  h_addr;
    logic [31:0] h_data;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        open_m = 1'b1; hard_m = 1'b0; win_valid = 1'b0; check_pending = 1'b0;
        win_start = 0; fails_m = 0; ckey = 32'd0; mem_m = '0; wr_hold = 1'b0;
    endtask

    task automatic model_step(input bit req_new, input logic [2:0] addr, input logic [31:0] data,
                              input bit commit, input bit unl, input logic [31:0] key);
        int e;
        bit in_win, writable, plain_locked, ok;
        e            = cyc + 1;
        in_win       = win_valid && ((e - 1 - win_start) <= WIN);
        writable     = open_m || in_win;
        plain_locked = !open_m && !in_win && !check_pending && !hard_m;
        if (req_new) begin
            ok = writable && (int'(addr) < NUM_REGS);
            wr_q.push_back('{e, ok});
            if (ok) mem_m[addr] = data;
        end
        if (commit && writable) begin
            open_m    = 1'b0;
            win_valid = 1'b0;
        end
        if (check_pending) begin
            check_pending = 1'b0;
            if (ckey == KEY) begin
                jt_q.push_back('{e, 1'b1});
                win_valid = 1'b1;
                win_start = e;
                fails_m   = 0;
            end else begin
                jt_q.push_back('{e, 1'b0});
                fails_m++;
                if (fails_m == MAXF) hard_m = 1'b1;
            end
        end else if (unl) begin
            if (plain_locked) begin
                check_pending = 1'b1;
                ckey          = key;
            end else begin
                jt_q.push_back('{e, 1'b0});
            end
        end
        st_q.push_back('{e, !open_m && !(win_valid && (e - win_start) <= WIN), mem_m});
    endtask

    task automatic drive_cycle(input bit req, input bit req_new, input logic [2:0] addr, input logic [31:0] data,
                               input bit commit, input bit unl, input logic [31:0] key);
        wr_req_i = req; wr_addr_i = addr; wr_data_i = data;
        lock_commit_i = commit; jtag_unlock_i = unl; jtag_key_i = key;
        model_step(req_new, addr, data, commit, unl, key);
        @(negedge clk_i);
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic apply_reset();
        rst_low = 1'b0;
        wr_req_i = 1'b0; lock_commit_i = 1'b0; jtag_unlock_i = 1'b0;
        #1;
        check_output("reset_outputs", 256'({wr_ack_o, wr_err_o, jtag_ack_o, jtag_nack_o, locked_o}), 256'(5'b0));
        check_output("reset_mem", 256'(reglk_mem_o), 256'(0));
        wr_q.delete(); jt_q.delete(); st_q.delete();
        model_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_low = 1'b1;
    endtask

    task automatic apply_stimulus();
        bit          req, nw, cm, un;
        logic [2:0]  a;
        logic [31:0] d, k;
        req = 1'b0; nw = 1'b0; a = h_addr; d = h_data;
        if (wr_hold) begin
            req = 1'b1; wr_hold = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
            h_addr = 3'($urandom_range(0, 7));
            h_data = $urandom;
            a = h_addr; d = h_data;
            req = 1'b1; nw = 1'b1; wr_hold = 1'b1;
        end
        cm = ($urandom_range(0, 15) == 0);
        un = !check_pending && ($urandom_range(0, 5) == 0);
        k  = ($urandom_range(0, 1) == 0) ? KEY : $urandom;
        drive_cycle(req, nw, a, d, cm, un, k);
    endtask

    // Monitor: pops an expectation whenever a response pulse appears or one falls due.
    always @(posedge clk_i) begin
        #1;
        if (rst_low) begin
            if (wr_ack_o || wr_err_o) begin
                if (wr_q.size() == 0) begin
                    check_output("wr_unexpected", 256'({wr_ack_o, wr_err_o}), 256'(2'b00));
                end else begin
                    mon_r = wr_q.pop_front();
                    check_output("wr_resp", 256'({cyc, wr_ack_o, wr_err_o}), 256'({mon_r.cyc, mon_r.ok, !mon_r.ok}));
                end
            end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
                mon_r = wr_q.pop_front();
                check_output("wr_missing", 256'({wr_ack_o, wr_err_o}), 256'({mon_r.ok, !mon_r.ok}));
            end
            if (jtag_ack_o || jtag_nack_o) begin
                if (jt_q.size() == 0) begin
                    check_output("jtag_unexpected", 256'({jtag_ack_o, jtag_nack_o}), 256'(2'b00));
                end else begin
                    mon_r = jt_q.pop_front();
                    check_output("jtag_resp", 256'({cyc, jtag_ack_o, jtag_nack_o}), 256'({mon_r.cyc, mon_r.ok, !mon_r.ok}));
                end
            end else if (jt_q.size() != 0 && jt_q[0].cyc <= cyc) begin
                mon_r = jt_q.pop_front();
                check_output("jtag_missing", 256'({jtag_ack_o, jtag_nack_o}), 256'({mon_r.ok, !mon_r.ok}));
            end
            if (st_q.size() != 0 && st_q[0].cyc == cyc) begin
                mon_s = st_q.pop_front();
                check_output("locked", 256'(locked_o), 256'(mon_s.locked));
                check_output("mem", 256'(reglk_mem_o), 256'(mon_s.mem));
            end
        end
    end

    initial begin
        int first;
        int len;
        model_reset();
        @(negedge clk_i);
        apply_reset();

        // Basic write, out-of-range write, then write+commit in the same cycle.
        drive_cycle(1'b1, 1'b1, 3'd2, 32'h0000_003F, 1'b0, 1'b0, 32'd0);
        check_output("open_wr_ack", 256'({wr_ack_o, wr_err_o}), 256'(2'b10));
        check_output("open_wr_data", 256'(reglk_mem_o[2]), 256'(32'h3F));
        drive_cycle(1'b1, 1'b0, 3'd2, 32'h0000_003F, 1'b0, 1'b0, 32'd0);
        drive_cycle(1'b1, 1'b1, 3'd6, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        check_output("addr6_err", 256'({wr_ack_o, wr_err_o}), 256'(2'b01));
        check_output("addr6_mem", 256'(reglk_mem_o), 256'({32'h0, 32'h0, 32'h0, 32'h3F, 32'h0, 32'h0}));
        drive_cycle(1'b1, 1'b0, 3'd6, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        drive_cycle(1'b1, 1'b1, 3'd5, 32'h0000_00A5, 1'b1, 1'b0, 32'd0);
        check_output("commit_wr_ack", 256'({wr_ack_o, wr_err_o}), 256'(2'b10));
        check_output("commit_wr_data", 256'(reglk_mem_o[5]), 256'(32'hA5));
        check_output("commit_locked", 256'(locked_o), 256'(1'b1));
        drive_cycle(1'b1, 1'b0, 3'd5, 32'h0000_00A5, 1'b0, 1'b0, 32'd0);
        drive_cycle(1'b1, 1'b1, 3'd2, 32'h0, 1'b0, 1'b0, 32'd0);
        check_output("locked_wr_err", 256'({wr_ack_o, wr_err_o}), 256'(2'b01));
        check_output("locked_wr_keep", 256'(reglk_mem_o[2]), 256'(32'h3F));
        drive_cycle(1'b1, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0, 32'd0);

        // Correct key opens a window of WIN+1 writable cycles.
        drive_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, KEY);
        check_output("check_locked", 256'(locked_o), 256'(1'b1));
        idle();
        check_output("unlock_ack", 256'({jtag_ack_o, jtag_nack_o}), 256'(2'b10));
        check_output("window_open", 256'(locked_o), 256'(1'b0));
        first = -1;
        for (int k = 1; k <= WIN + 4; k++) begin
            if (k == 1)      drive_cycle(1'b1, 1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
            else if (k == 2) drive_cycle(1'b1, 1'b0, 3'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
            else             idle();
            if (k == 1) check_output("window_wr_ack", 256'({wr_ack_o, wr_err_o}), 256'(2'b10));
            if (locked_o && first < 0) first = k;
        end
        check_output("window_len", 256'(first), 256'(WIN + 1));

        // Second window closed early by commit.
        drive_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, KEY);
        idle();
        check_output("unlock2_ack", 256'({jtag_ack_o, jtag_nack_o}), 256'(2'b10));
        drive_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        check_output("window_commit", 256'(locked_o), 256'(1'b1));

        // Three bad keys lead to hard lock, which even the right key cannot leave.
        for (int i = 0; i < MAXF; i++) begin
            drive_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, KEY ^ 32'(i + 1));
            idle();
            check_output("badkey_nack", 256'({jtag_ack_o, jtag_nack_o}), 256'(2'b01));
        end
        check_output("hard_locked", 256'(locked_o), 256'(1'b1));
        drive_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, KEY);
        check_output("hard_key_nack", 256'({jtag_ack_o, jtag_nack_o}), 256'(2'b01));
        idle();
        check_output("hard_no_ack", 256'(jtag_ack_o), 256'(1'b0));
        drive_cycle(1'b1, 1'b1, 3'd1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
        check_output("hard_wr_err", 256'({wr_ack_o, wr_err_o}), 256'(2'b01));
        drive_cycle(1'b1, 1'b0, 3'd1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
        apply_reset();
        drive_cycle(1'b1, 1'b1, 3'd0, 32'h0000_0055, 1'b0, 1'b0, 32'd0);
        check_output("post_reset_ack", 256'({wr_ack_o, wr_err_o}), 256'(2'b10));
        drive_cycle(1'b1, 1'b0, 3'd0, 32'h0000_0055, 1'b0, 1'b0, 32'd0);

        // Random episodes, each ended by a reset at an arbitrary point.
        for (int ep = 0; ep < 8; ep++) begin
            len = $urandom_range(60, 160);
            for (int c = 0; c < len; c++) apply_stimulus();
            apply_reset();
        end
        idle();
        idle();
        check_output("wr_q_drained", 256'(wr_q.size()), 256'(0));
        check_output("jt_q_drained", 256'(jt_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
